// File: rtl/bmf_part_pkg.sv
// Shared types, widths and the round-robin pick helper for the BMF partition arbiter.
package bmf_part_pkg;

  localparam int PART_W  = 10;
  localparam int CNT_W   = 16;
  localparam int MAX_REQ = 8;

  typedef logic [PART_W-1:0] part_word_t;

  // First eligible requester at or after ptr, scanning upward modulo nreq; one-hot or zero.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] eligible,
                                                 input logic [2:0]         ptr,
                                                 input int                 nreq);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < nreq) begin
        idx = int'(ptr) + k;
        if (idx >= nreq) begin
          idx = idx - nreq;
        end else begin
          idx = idx;
        end
        if (!found && eligible[idx[2:0]]) begin
          gnt[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/bmf_rr_arbiter.sv
// Combinational round-robin grant: one-hot grant, its index, and the pointer to use after it.
module bmf_rr_arbiter
  import bmf_part_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  ptr,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic [IDW-1:0]  ptr_next
);

  logic [MAX_REQ-1:0] elig_pad_s;
  logic [MAX_REQ-1:0] pick_s;

  // Widen to the helper's fixed width and gate the pick with advance.
  always_comb begin
    elig_pad_s             = '0;
    elig_pad_s[NREQ-1:0]   = eligible;
    pick_s                 = rr_pick(elig_pad_s, 3'(ptr), NREQ);
    if (advance) begin
      grant = pick_s[NREQ-1:0];
    end else begin
      grant = '0;
    end
  end

  // Encode the granted index and the wrap-around successor pointer.
  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_id = IDW'(i);
      end else begin
        grant_id = grant_id;
      end
    end
    if (grant_id == IDW'(NREQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_id + IDW'(1);
    end
  end

endmodule

// File: rtl/bmf_part_arbiter.sv
// Time-shares one combinational BMF partition among NREQ requesters through a
// 2-stage stall-able pipeline; responses carry the originating requester id.
module bmf_part_arbiter
  import bmf_part_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = PART_W,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_data,
  output logic [W-1:0]    dp_in,
  input  logic [W-1:0]    dp_out,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [W-1:0]    resp_data,
  output logic [IDW-1:0]  resp_id,
  input  logic [NREQ-1:0] cfg_mask,
  input  logic            cfg_bypass,
  output logic [CNT_W-1:0] op_count
);

  logic            s1_v_r, s2_v_r;
  logic [IDW-1:0]  s1_id_r, s2_id_r, rr_ptr_r;
  logic [W-1:0]    s1_op_r, s2_data_r;
  logic [CNT_W-1:0] cnt_r;

  logic            s1_load_s, s2_load_s, gnt_any_s;
  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  gnt_id_s, ptr_next_s;
  logic [W-1:0]    gnt_op_s;

  assign s2_load_s = s1_v_r & (~s2_v_r | resp_ready);
  assign s1_load_s = ~s1_v_r | s2_load_s;
  assign gnt_any_s = |grant_s;

  // Reset gates advance so no requester sees ready while rst_n is low.
  bmf_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .eligible (req_valid & cfg_mask),
    .ptr      (rr_ptr_r),
    .advance  (s1_load_s & rst_n),
    .grant    (grant_s),
    .grant_id (gnt_id_s),
    .ptr_next (ptr_next_s)
  );

  // Select the granted requester's operand.
  always_comb begin
    gnt_op_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        gnt_op_s = req_data[i*W +: W];
      end else begin
        gnt_op_s = gnt_op_s;
      end
    end
  end

  // Stage 1: operand register drives the partition; idle loads keep dp_in quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_r   <= 1'b0;
      s1_id_r  <= '0;
      s1_op_r  <= '0;
      rr_ptr_r <= '0;
    end else if (s1_load_s) begin
      if (gnt_any_s) begin
        s1_v_r   <= 1'b1;
        s1_id_r  <= gnt_id_s;
        s1_op_r  <= gnt_op_s;
        rr_ptr_r <= ptr_next_s;
      end else begin
        s1_v_r <= 1'b0;
      end
    end else begin
      s1_v_r <= s1_v_r;
    end
  end

  // Stage 2: capture partition result (or operand in bypass) and hold it while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v_r    <= 1'b0;
      s2_id_r   <= '0;
      s2_data_r <= '0;
    end else if (s2_load_s) begin
      s2_v_r    <= 1'b1;
      s2_id_r   <= s1_id_r;
      s2_data_r <= cfg_bypass ? s1_op_r : dp_out;
    end else if (resp_ready) begin
      s2_v_r <= 1'b0;
    end else begin
      s2_v_r <= s2_v_r;
    end
  end

  // Saturating count of completed response handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (s2_v_r & resp_ready & ~(&cnt_r)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign req_ready  = grant_s;
  assign dp_in      = s1_op_r;
  assign resp_valid = s2_v_r;
  assign resp_id    = s2_id_r;
  assign resp_data  = s2_data_r;
  assign op_count   = cnt_r;

endmodule

// File: tb/tb_bmf_part_arbiter.sv
// Directed bench for bmf_part_arbiter: stimulus pushes expected responses, a negedge
// monitor pops and compares them and also evaluates per-cycle expectations.
module tb_bmf_part_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [9:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [39:0] req_data;
  logic [9:0]  dp_in, dp_out;
  logic        resp_valid, resp_ready;
  logic [9:0]  resp_data;
  logic [1:0]  resp_id;
  logic [3:0]  cfg_mask;
  logic        cfg_bypass;
  logic [15:0] op_count;

  int checks   = 0;
  int failures = 0;
  int rd_idx   = 0;
  exp_t exp_q[$];

  logic       en_rdy, en_rv, en_dp, en_cnt, en_rd, en_qe;
  logic [3:0]  x_rdy;
  logic        x_rv;
  logic [9:0]  x_dp, x_rd;
  logic [15:0] x_cnt;
  int          exp_ptr;

  bmf_part_arbiter #(.NREQ(4), .W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .dp_in      (dp_in),
    .dp_out     (dp_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .cfg_mask   (cfg_mask),
    .cfg_bypass (cfg_bypass),
    .op_count   (op_count)
  );

  // Model partition: bitwise inverter.
  assign dp_out = ~dp_in;

  always #5 clk = ~clk;

  function automatic logic [9:0] dval(input int i);
    case (i)
      0:       return 10'h011;
      1:       return 10'h122;
      2:       return 10'h233;
      3:       return 10'h344;
      default: return 10'h000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: per-cycle expectations plus scoreboard pop on each response handshake.
  always @(negedge clk) begin
    if (en_rdy) chk("req_ready", {28'd0, req_ready}, {28'd0, x_rdy});
    if (en_rv)  chk("resp_valid", {31'd0, resp_valid}, {31'd0, x_rv});
    if (en_dp)  chk("dp_in", {22'd0, dp_in}, {22'd0, x_dp});
    if (en_cnt) chk("op_count", {16'd0, op_count}, {16'd0, x_cnt});
    if (en_rd)  chk("resp_data_stall", {22'd0, resp_data}, {22'd0, x_rd});
    if (en_qe)  chk("drain_pending", rd_idx, exp_q.size());
    if (rst_n && resp_valid && resp_ready) begin
      if (rd_idx >= exp_q.size()) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual id=%0d data=%0h required none", resp_id, resp_data);
      end else begin
        chk("resp_id", {30'd0, resp_id}, {30'd0, exp_q[rd_idx].id});
        chk("resp_data", {22'd0, resp_data}, {22'd0, exp_q[rd_idx].data});
        rd_idx++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    en_rdy = 1'b0; en_rv = 1'b0; en_dp = 1'b0;
    en_cnt = 1'b0; en_rd = 1'b0; en_qe = 1'b0;
  endtask

  task automatic push(input int id, input logic [9:0] data);
    exp_q.push_back('{id: 2'(id), data: data});
  endtask

  task automatic drain();
    int n = 0;
    while (rd_idx != exp_q.size() && n < 20) begin
      step();
      n++;
    end
    en_qe = 1'b1;
  endtask

  // All requesters valid, full mask, bypass: n back-to-back grants in pointer order.
  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      req_valid = 4'hF;
      en_rdy = 1'b1; x_rdy = 4'(1 << exp_ptr);
      push(exp_ptr, dval(exp_ptr));
      exp_ptr = (exp_ptr + 1) % 4;
    end
    step();
    req_valid = 4'h0;
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en_rdy = 1'b0; en_rv = 1'b0; en_dp = 1'b0;
    en_cnt = 1'b0; en_rd = 1'b0; en_qe = 1'b0;
    x_rdy = 4'h0; x_rv = 1'b0; x_dp = 10'h0; x_rd = 10'h0; x_cnt = 16'h0;
    rst_n = 1'b0; req_valid = 4'h0; cfg_mask = 4'hF; cfg_bypass = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i*10 +: 10] = dval(i);

    // Reset state, with requests pending to show ready stays low in reset.
    step();
    step();
    req_valid = 4'hF;
    en_rdy = 1'b1; x_rdy = 4'h0; en_rv = 1'b1; x_rv = 1'b0;
    en_dp = 1'b1; x_dp = 10'h000; en_cnt = 1'b1; x_cnt = 16'h0000;

    // Single request on id 2, bypass: latency 0/1/2.
    step();
    rst_n = 1'b1; req_valid = 4'b0100; req_data[20 +: 10] = 10'h2A5;
    en_rdy = 1'b1; x_rdy = 4'b0100;
    push(2, 10'h2A5);
    step();
    req_valid = 4'h0;
    en_dp = 1'b1; x_dp = 10'h2A5; en_rv = 1'b1; x_rv = 1'b0;
    step();
    en_rv = 1'b1; x_rv = 1'b1;
    step();
    en_cnt = 1'b1; x_cnt = 16'd1; en_rv = 1'b1; x_rv = 1'b0;
    req_data[20 +: 10] = dval(2);

    // Round-robin, pointer now 3: grants 3,0,1,2,3,0,1,2 back-to-back.
    for (int k = 0; k < 8; k++) begin
      step();
      req_valid = 4'hF;
      en_rdy = 1'b1; x_rdy = 4'(1 << ((3 + k) % 4));
      push((3 + k) % 4, dval((3 + k) % 4));
      if (k >= 2) begin
        en_rv = 1'b1; x_rv = 1'b1;
      end
    end
    step();
    req_valid = 4'h0;
    en_rv = 1'b1; x_rv = 1'b1;
    drain();

    // Backpressure, pointer 3: two grants (3,0), then none; release grants 1.
    step();
    resp_ready = 1'b0; req_valid = 4'hF;
    en_rdy = 1'b1; x_rdy = 4'b1000; push(3, dval(3));
    step();
    en_rdy = 1'b1; x_rdy = 4'b0001; push(0, dval(0));
    en_rv = 1'b1; x_rv = 1'b0;
    for (int k = 2; k < 5; k++) begin
      step();
      en_rdy = 1'b1; x_rdy = 4'b0000;
      en_rv = 1'b1; x_rv = 1'b1; en_rd = 1'b1; x_rd = dval(3);
    end
    step();
    resp_ready = 1'b1;
    en_rdy = 1'b1; x_rdy = 4'b0010; push(1, dval(1));
    step();
    req_valid = 4'h0;
    drain();

    // Mask 1010, partition path (inverter), pointer 2: grants 3,1,3,1.
    step();
    cfg_mask = 4'b1010; cfg_bypass = 1'b0; req_valid = 4'hF; req_data[10 +: 10] = 10'h0F0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      en_rdy = 1'b1;
      if (k % 2 == 0) begin
        x_rdy = 4'b1000; push(3, 10'h0BB);
      end else begin
        x_rdy = 4'b0010; push(1, 10'h30F);
      end
    end
    step();
    req_valid = 4'h0;
    drain();
    step();
    cfg_mask = 4'hF; cfg_bypass = 1'b1; req_data[10 +: 10] = dval(1);

    // Mid-flight reset: ids 2,3 in flight are discarded; first grant after is id 1.
    step();
    resp_ready = 1'b0; req_valid = 4'hF;
    en_rdy = 1'b1; x_rdy = 4'b0100;
    step();
    en_rdy = 1'b1; x_rdy = 4'b1000;
    step();
    rst_n = 1'b0;
    en_rdy = 1'b1; x_rdy = 4'b0000;
    step();
    rst_n = 1'b1; resp_ready = 1'b1; req_valid = 4'b0110;
    en_rdy = 1'b1; x_rdy = 4'b0010; en_rv = 1'b1; x_rv = 1'b0;
    en_cnt = 1'b1; x_cnt = 16'd0;
    push(1, dval(1));
    step();
    req_valid = 4'h0;
    en_rv = 1'b1; x_rv = 1'b0; en_dp = 1'b1; x_dp = dval(1);
    drain();
    en_cnt = 1'b1; x_cnt = 16'd1;

    // Saturation: 1 + 65533 = FFFE, then FFFF, then holds.
    exp_ptr = 2;
    burst(65533);
    en_cnt = 1'b1; x_cnt = 16'hFFFE;
    burst(1);
    en_cnt = 1'b1; x_cnt = 16'hFFFF;
    burst(2);
    en_cnt = 1'b1; x_cnt = 16'hFFFF;

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bmf_part_arbiter.md
# bmf_part_arbiter

Time-shares one combinational approximate-multiplier partition (BMF compressor plus decompressor, 10-bit in / 10-bit out) among several requesters. It sits between the partition netlist and its consumers. It arbitrates round-robin, registers the partition input and the captured result in a 2-stage stall-able pipeline, and returns each result tagged with the requester id. A configuration mask and a bypass mode let the integration disable requesters or skip the approximate datapath for debug.

## Interface

Parameters:

- `NREQ`, 4, number of requesters (2..8)
- `W`, 10, partition input/output width (in width = out width)
- `IDW`, `$clog2(NREQ)`, response id width (derived, not overridable)

Ports:

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept (one-hot or zero)
- `req_data`  in  NREQ*W  requester i operand at bits [i*W +: W]
- `dp_in`  out  W  drives the shared partition inputs `pi00..pi09`
- `dp_out`  in  W  partition outputs `po00..po09`, combinational from `dp_in`
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  consumer accepts result
- `resp_data`  out  W  result
- `resp_id`  out  IDW  index of the originating requester
- `cfg_mask`  in  NREQ  1 = requester enabled
- `cfg_bypass`  in  1  1 = result is the operand itself, not `dp_out`
- `op_count`  out  16  completed responses, saturating

## Operation

- **Pipeline state:**
  - S1 holds {`s1_v`, id, operand}; its operand register *is* `dp_in`.
  - S2 holds {`s2_v`, id, result}; it drives `resp_*` directly.
- **Advance rules:**
  - `s2_load = s1_v & (~s2_v | resp_ready)`
  - `s1_load = ~s1_v | s2_load`
- **Eligibility and grant:**
  - Requester i is eligible when `req_valid[i] & cfg_mask[i]`.
  - When `s1_load` is high and any requester is eligible, exactly one is granted: the first eligible at or after `rr_ptr`, scanning upward modulo NREQ.
  - `req_ready[i]` = grant[i]. It is combinational and may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
  - A handshake occurs when `req_valid[i] & req_ready[i]`.
- **On grant:**
  - S1 loads {1, i, `req_data[i]`}.
  - `rr_ptr` <= (i+1) mod NREQ.
- **S1 load with no grant:** `s1_v` <= 0. Operand and id are held, so `dp_in` does not toggle while S1 is idle.
- **On `s2_load`:**
  - S2 loads {1, S1 id, `cfg_bypass` ? S1 operand : `dp_out`}.
  - `cfg_bypass` is sampled only at this edge.
- **Response drain:** if `s2_v & resp_ready` and there is no `s2_load`, `s2_v` <= 0.
- **`op_count`:** increments on each `resp_valid & resp_ready` and saturates at 16'hFFFF.
- **`cfg_mask`:** sampled only at grant. Clearing a bit never cancels a request already in S1 or S2.
- **Disabled requesters:** a masked requester sees `req_ready` = 0 permanently.

## Timing

- **Reset values** (any edge with `rst_n`=0):
  - `s1_v`, `s2_v`, `resp_valid` = 0
  - `dp_in` = 0, `resp_data` = 0, `resp_id` = 0
  - `rr_ptr` = 0, `op_count` = 0
  - `req_ready` = 0 while in reset
- **Reset mid-operation:** in-flight operations are discarded with no response.
- **Latency:** handshake in cycle N gives `dp_in` valid in cycle N+1 and `resp_valid` in cycle N+2 (with no stall).
- **Throughput:** one operation per cycle while `resp_ready` = 1.
- **Response stall:**
  - `resp_ready` = 0 with S2 full holds S2. S1 fills once, then `req_ready` = 0 for all.
  - Maximum 2 operations buffered; none is lost or duplicated.
  - When `resp_ready` rises, S2 drains and S1 advances in the same cycle, and a new grant in that same cycle is allowed.
- **Combinational path:** `dp_out` must settle within one cycle of `dp_in`; S2 captures it one cycle after S1 loads.
- **Simultaneous events:**
  - Response handshake and `s2_load` in one cycle: S2 is replaced and `s2_v` stays 1.
  - `op_count` at 16'hFFFF holds.
- **Stable response:** `resp_data` and `resp_id` are stable while `resp_valid & ~resp_ready`.

## Structure

- **Shared package `bmf_part_pkg`:**
  - `PART_W` = 10
  - `CNT_W` = 16
  - typedef `part_word_t` (logic [PART_W-1:0])
  - function `rr_pick(eligible, ptr)`, returning a one-hot grant
- **Sub-module:** one natural sub-module, `bmf_rr_arbiter` (eligible vector, `ptr`, `advance`, returning a one-hot grant and the updated pointer). Pipeline registers and the counter stay in the top.
- **Partition instantiation:** the partition itself is instantiated by the integrator, outside this block.

## Test plan

- **Single request, no stall:** reset, then `req_valid[2]`=1 with `req_data[2]`=10'h2A5 and `cfg_bypass`=1 → `req_ready[2]` in cycle 0, `dp_in`=10'h2A5 in cycle 1, and `resp_valid`/`resp_id`=2/`resp_data`=10'h2A5 in cycle 2. `op_count`=1.
- **Round-robin fairness:** all 4 requesters held valid, `resp_ready`=1 → grants in order 0,1,2,3,0,… and responses back-to-back every cycle with matching ids.
- **Backpressure:** `resp_ready`=0 for 5 cycles with all requesters valid → exactly 2 grants, then all `req_ready`=0. `resp_data` is stable. On release, no loss and in-order ids.
- **Mask and bypass:** `cfg_mask`=4'b1010 with all valid → only ids 1 and 3 are granted. With `cfg_bypass`=0 and a model partition (`dp_out`=~`dp_in`), operand 10'h0F0 returns 10'h30F.
- **Mid-flight reset:** two operations in flight, `rst_n` low for 1 cycle → no `resp_valid` afterwards, `op_count`=0, and the first post-reset grant goes to the lowest eligible id.
- **Counter saturation:** force 65,536+ completions (or preload via hierarchical force to 16'hFFFE) → reaches 16'hFFFF and holds.
